quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 117 +++++++++++
 tb/tb_quad_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
`timescale 1ns/1ps
// Quadrature encoder decoder: synchronise, debounce, decode steps.
// Emits count_en/direction pulses and a sticky double-step error.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic quad_a,
  input  logic quad_b,
  input  logic err_clr,
  output logic direction,
  output logic count_en,
  output logic step_err,
  output logic armed
);

  localparam logic [3:0] FMAX = 4'(FILTER_LEN - 1);
  localparam logic [4:0] SMAX = 5'(SYNC_STAGES + FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             pin_s;
  logic [1:0]             filt;
  logic [1:0]             filt_nxt;
  logic [1:0]             prev;
  logic [1:0][3:0]        cnt;
  logic [1:0][3:0]        cnt_nxt;
  logic [4:0]             st;
  logic [3:0]             mv;
  logic                   up;
  logic                   dn;
  logic                   dbl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], quad_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], quad_b};
    end
  end

  assign pin_s = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Counter resets on agreement and on acceptance, so it tops out at FMAX.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = '0;
    for (int i = 0; i < 2; i++) begin
      if (pin_s[i] != filt[i]) begin
        if (cnt[i] >= FMAX)
          filt_nxt[i] = pin_s[i];
        else
          cnt_nxt[i] = cnt[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt <= '0;
      cnt  <= '0;
    end else begin
      filt <= filt_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign mv  = {prev, filt};
  assign dbl = (prev ^ filt) == 2'b11;

  always_comb begin
    up = 1'b0;
    dn = 1'b0;
    case (mv)
      4'b0010, 4'b1011,
      4'b1101, 4'b0100: up = 1'b1;
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: dn = 1'b1;
      default: ;
    endcase
  end

  // During startup prev follows the filter's next value so the
  // first armed cycle compares against a settled pair.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev      <= '0;
      st        <= '0;
      armed     <= 1'b0;
      count_en  <= 1'b0;
      direction <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      if (!armed) begin
        prev     <= filt_nxt;
        st       <= st + 5'd1;
        count_en <= 1'b0;
        if (st == SMAX)
          armed <= 1'b1;
      end else begin
        prev     <= filt;
        count_en <= up | dn;
        if (up | dn)
          direction <= dn;
      end
      if (armed && dbl)
        step_err <= 1'b1;
      else if (err_clr)
        step_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
`timescale 1ns/1ps
// Directed bench for quad_decoder with default parameters.
module tb_quad_decoder;

  logic clk = 1'b0;
  logic rstn;
  logic quad_a;
  logic quad_b;
  logic err_clr;
  logic direction;
  logic count_en;
  logic step_err;
  logic armed;

  int vectors = 0;
  int miscompares = 0;

  quad_decoder dut (
    .clk       (clk),
    .rstn      (rstn),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .err_clr   (err_clr),
    .direction (direction),
    .count_en  (count_en),
    .step_err  (step_err),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a new pin pair, expect a pulse on the 6th edge only.
  task automatic mv(input logic a, input logic b, input logic d,
                    input string tag);
    quad_a = a;
    quad_b = b;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6) begin
        chk({tag, "_en"}, 8'(count_en), 8'd1);
        chk({tag, "_dir"}, 8'(direction), 8'(d));
      end else begin
        chk({tag, "_idle"}, 8'(count_en), 8'd0);
      end
    end
  endtask

  initial begin
    rstn    = 1'b0;
    quad_a  = 1'b1;
    quad_b  = 1'b1;
    err_clr = 1'b0;
    step();
    step();
    chk("reset_outs", 8'({direction, count_en, step_err, armed}), 8'h0);
    chk("reset_filt", 8'(dut.filt), 8'h0);

    rstn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("start_en", 8'(count_en), 8'd0);
      chk("start_err", 8'(step_err), 8'd0);
      chk("start_armed", 8'(armed), (i == 5) ? 8'd1 : 8'd0);
    end
    chk("start_prev", 8'(dut.prev), 8'b11);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("start_quiet", 8'({count_en, step_err}), 8'h0);
    end

    mv(1'b0, 1'b1, 1'b0, "init_01");
    mv(1'b0, 1'b0, 1'b0, "init_00");

    mv(1'b1, 1'b0, 1'b0, "up_10");
    mv(1'b1, 1'b1, 1'b0, "up_11");
    mv(1'b0, 1'b1, 1'b0, "up_01");
    mv(1'b0, 1'b0, 1'b0, "up_00");

    mv(1'b0, 1'b1, 1'b1, "dn_01");
    mv(1'b1, 1'b1, 1'b1, "dn_11");
    mv(1'b1, 1'b0, 1'b1, "dn_10");
    mv(1'b0, 1'b0, 1'b1, "dn_00");
    for (int i = 0; i < 5; i++) step();
    chk("dir_hold", 8'(direction), 8'd1);

    quad_a = 1'b1;
    step();
    step();
    quad_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_en", 8'(count_en), 8'd0);
    end
    chk("glitch_filt", 8'(dut.filt), 8'b00);

    mv(1'b1, 1'b0, 1'b0, "stable_10");
    mv(1'b0, 1'b0, 1'b1, "rev_00");

    quad_a = 1'b1;
    quad_b = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("dbl_en", 8'(count_en), 8'd0);
      chk("dbl_err", 8'(step_err), (i >= 6) ? 8'd1 : 8'd0);
    end
    chk("dbl_dir", 8'(direction), 8'd1);
    chk("dbl_prev", 8'(dut.prev), 8'b11);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err", 8'(step_err), 8'd0);

    quad_a = 1'b0;
    quad_b = 1'b0;
    for (int i = 0; i < 5; i++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_vs_set", 8'(step_err), 8'd1);
    chk("clr_vs_set_en", 8'(count_en), 8'd0);
    step();
    chk("err_sticky", 8'(step_err), 8'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_again", 8'(step_err), 8'd0);

    quad_a = 1'b1;
    step();
    step();
    rstn = 1'b0;
    #1;
    chk("async_rst", 8'({direction, count_en, step_err, armed}), 8'h0);
    step();
    step();
    rstn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("rst_outs", 8'({direction, count_en, step_err, armed}),
          (i >= 5) ? 8'h1 : 8'h0);
    end
    chk("rst_prev", 8'(dut.prev), 8'b10);

    mv(1'b1, 1'b1, 1'b0, "post_rst_11");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
